rr_mux_4_1: RTL

Registered 4:1 round-robin multiplexer. It gathers four valid/ready source channels into one output stream, the reverse of the 1:4 demultiplexer path. Each output beat is tagged with its source channel index, so the downstream DEMUX_1_4 can route it back out. Arbitration is fair round-robin, output latency is one cycle, and full throughput is one beat per clock.

---
 rtl/rr_mux_pkg.sv | 20 ++
 rtl/rr_arbiter_4.sv | 38 +++
 rtl/rr_mux_4_1.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the 4:1 round-robin multiplexer.
// Latency: none; holds only constants, types and a helper function.
// Backpressure: not applicable.
package rr_mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Occupancy of the single output register
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Round-robin pointer successor; the 2-bit add wraps 3 -> 0
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] g);
    return g + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin arbiter with optional lock to one channel.
// Latency: zero (purely combinational).
// Backpressure: none; the caller decides whether a grant is consumed.
module rr_arbiter_4
  import rr_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] request,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              lock_en,
  input  logic [SEL_W-1:0]  lock_ch,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  logic [SEL_W-1:0] idx;

  // First requester found circularly from ptr; when locked only lock_ch may win.
  // The loop runs from the farthest offset down so the nearest requester
  // is the last assignment and therefore wins.
  always_comb begin
    grant       = ptr;
    grant_valid = 1'b0;
    idx         = ptr;
    if (lock_en) begin
      grant       = lock_ch;
      grant_valid = request[lock_ch];
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = ptr + SEL_W'(k);
        if (request[idx]) begin
          grant       = idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_mux_4_1.sv
// Registered 4:1 round-robin mux; output beat tagged with source index. Optional packet lock: RR_MUX_4_1_LOCK_EN.
// Latency: one cycle from accept to Valid_Out; one beat per clock sustained.
// Backpressure: Ready_In=0 freezes the held beat and drops all Ready_Out; Enable_In=0 blocks new grants only.
module rr_mux_4_1
  import rr_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         Clock_In,
  input  logic                         Reset_In,
  input  logic                         Enable_In,
  input  logic [NUM_CH*DATA_WIDTH-1:0] Data_In,
  input  logic [NUM_CH-1:0]            Valid_In,
  input  logic [NUM_CH-1:0]            Last_In,
  output logic [NUM_CH-1:0]            Ready_Out,
  output logic [DATA_WIDTH-1:0]        Data_Out,
  output logic [SEL_W-1:0]             Select_Out,
  output logic                         Valid_Out,
  input  logic                         Ready_In
);

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             drain;
  logic             can_load;
  logic             accept;
  logic             ptr_adv;
  logic             lock_en;
  logic [SEL_W-1:0] lock_ch;

  rr_arbiter_4 u_arb (
    .request     (Valid_In),
    .ptr         (ptr_q),
    .lock_en     (lock_en),
    .lock_ch     (lock_ch),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign Valid_Out = (state_q == FULL);
  assign drain     = Valid_Out & Ready_In;
  assign can_load  = (state_q == EMPTY) | drain;
  // Reset_In gates accept so no source sees a handshake while reset is held
  assign accept    = ~Reset_In & Enable_In & can_load & grant_valid;

  // One-hot ready toward the granted source only
  always_comb begin
    Ready_Out = '0;
    if (accept) begin
      Ready_Out[grant] = 1'b1;
    end
  end

`ifdef RR_MUX_4_1_LOCK_EN
  logic             locked_q;
  logic [SEL_W-1:0] lock_ch_q;

  // Lock onto a channel mid-packet; a beat with Last_In set releases it
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      locked_q  <= 1'b0;
      lock_ch_q <= '0;
    end else if (accept) begin
      locked_q  <= ~Last_In[grant];
      lock_ch_q <= grant;
    end
  end

  assign lock_en = locked_q;
  assign lock_ch = lock_ch_q;
  // Pointer moves on only when a packet ends, so the lock owner keeps priority
  assign ptr_adv = accept & Last_In[grant];
`else
  logic unused_last;

  assign unused_last = ^Last_In;
  assign lock_en     = 1'b0;
  assign lock_ch     = '0;
  assign ptr_adv     = accept;
`endif

  // Occupancy state register
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy: fill on accept, empty on drain without a refill
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (drain & ~accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output payload and source tag load on accept, otherwise hold
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      Data_Out   <= '0;
      Select_Out <= '0;
    end else if (accept) begin
      Data_Out   <= Data_In[grant*DATA_WIDTH +: DATA_WIDTH];
      Select_Out <= grant;
    end
  end

  // Round-robin pointer: one past the last granted channel
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      ptr_q <= '0;
    end else if (ptr_adv) begin
      ptr_q <= next_ptr(grant);
    end
  end

endmodule
